multi_cycle_control: RTL and testbench

- Multi-cycle main control FSM for the MIPS-like datapath. It replaces the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB/BRANCH/JUMP and drives per-state datapath controls.
- Stalls on a memory-ready handshake, flags illegal opcodes and counts retired instructions.
- Sits between the instruction register (opcode field) and the shared-memory multi-cycle datapath.

---
 rtl/multi_cycle_control.sv | 177 +++++++++++++++++
 tb/tb_multi_cycle_control.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// Multi-cycle main control FSM for the MIPS-like shared-memory datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB/BRANCH/JUMP and counts retired instructions.
module multi_cycle_control #(
  parameter int OPCODE_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                ExtOp,
  output logic                ALUsrcA,
  output logic [1:0]          ALUsrcB,
  output logic [1:0]          ALUop,
  output logic [1:0]          PCSource,
  output logic                illegal_op,
  output logic                instr_done,
  output logic [CNT_W-1:0]    instr_count,
  output logic [2:0]          state_out
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_BRANCH = 3'd6,
    S_JUMP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    OP_R    = 3'd0,
    OP_LW   = 3'd1,
    OP_SW   = 3'd2,
    OP_BEQ  = 3'd3,
    OP_ADDI = 3'd4,
    OP_JMP  = 3'd5,
    OP_ILL  = 3'd6
  } op_t;

  // Opcode values above the field's range simply never occur, so a narrow
  // OPCODE_W naturally loses ADDI and JMP.
  function automatic op_t classify(input logic [OPCODE_W-1:0] o);
    case (32'(o))
      0:       return OP_R;
      1:       return OP_LW;
      2:       return OP_SW;
      3:       return OP_BEQ;
      4:       return OP_ADDI;
      5:       return OP_JMP;
      default: return OP_ILL;
    endcase
  endfunction

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [CNT_W-1:0]  count_q;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d    = state_q;
    op_d       = op_q;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    ExtOp      = 1'b0;
    ALUsrcA    = 1'b0;
    ALUsrcB    = 2'b00;
    ALUop      = 2'b00;
    PCSource   = 2'b00;
    illegal_op = 1'b0;
    instr_done = 1'b0;

    unique case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUsrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        op_d    = classify(opcode);
        ALUsrcB = 2'b11;
        ExtOp   = 1'b1;
        unique case (op_d)
          OP_R, OP_LW, OP_SW, OP_ADDI: state_d = S_EXEC;
          OP_BEQ:                      state_d = S_BRANCH;
          OP_JMP:                      state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        ALUsrcA = 1'b1;
        if (op_q == OP_R) begin
          ALUop = 2'b10;
        end else begin
          ALUsrcB = 2'b10;
          ExtOp   = 1'b1;
        end
        state_d = (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
      end
      S_MEM: begin
        MemRead  = (op_q == OP_LW);
        MemWrite = (op_q == OP_SW);
        if (mem_ready) begin
          if (op_q == OP_SW) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        RegDst     = (op_q == OP_R);
        MemtoReg   = (op_q == OP_LW);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        ALUsrcA    = 1'b1;
        ALUop      = 2'b01;
        PCSource   = 2'b01;
        PCWrite    = zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        PCSource   = 2'b10;
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_RST;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      op_q    <= OP_R;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      if (instr_done) count_q <= count_q + CNT_W'(1);
    end
  end

  assign instr_count = count_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized scoreboard bench for multi_cycle_control: a phase-sequence model
// pushes per-cycle expectations, a monitor pops and compares them.
module tb_multi_cycle_control;

  localparam int P_RST = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3,
                 P_MEM = 4, P_WB = 5, P_BRANCH = 6, P_JUMP = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  opcode;
  logic        zero, mem_ready;
  logic        PCWrite, IRWrite, RegWrite, RegDst, MemtoReg, MemRead, MemWrite;
  logic        ExtOp, ALUsrcA, illegal_op, instr_done;
  logic [1:0]  ALUsrcB, ALUop, PCSource;
  logic [15:0] instr_count;
  logic [2:0]  state_out;

  logic        w2_pcw, w2_irw, w2_rw, w2_rd, w2_m2r, w2_mrd, w2_mwr, w2_ext, w2_asa;
  logic        w2_ill, w2_done;
  logic [1:0]  w2_asb, w2_aop, w2_pcs;
  logic [1:0]  w2_count;
  logic [2:0]  w2_state;

  multi_cycle_control #(.OPCODE_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite), .ExtOp(ExtOp),
    .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB), .ALUop(ALUop), .PCSource(PCSource),
    .illegal_op(illegal_op), .instr_done(instr_done), .instr_count(instr_count),
    .state_out(state_out)
  );

  multi_cycle_control #(.OPCODE_W(3), .CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(w2_pcw), .IRWrite(w2_irw), .RegWrite(w2_rw), .RegDst(w2_rd),
    .MemtoReg(w2_m2r), .MemRead(w2_mrd), .MemWrite(w2_mwr), .ExtOp(w2_ext),
    .ALUsrcA(w2_asa), .ALUsrcB(w2_asb), .ALUop(w2_aop), .PCSource(w2_pcs),
    .illegal_op(w2_ill), .instr_done(w2_done), .instr_count(w2_count),
    .state_out(w2_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [16:0] ctrl;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [16:0] act_ctrl;
  assign act_ctrl = {PCWrite, IRWrite, RegWrite, RegDst, MemtoReg, MemRead, MemWrite,
                     ExtOp, ALUsrcA, ALUsrcB, ALUop, PCSource, illegal_op, instr_done};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Control word each phase should present, straight from the per-state table.
  function automatic logic [16:0] ctrl_of(input int ph, input int op, input logic mr,
                                          input logic z);
    logic pcw, irw, rw, rd, m2r, mrd, mwr, ext, asa, ill, done;
    logic [1:0] asb, aop, pcs;
    {pcw, irw, rw, rd, m2r, mrd, mwr, ext, asa, ill, done} = '0;
    {asb, aop, pcs} = '0;
    case (ph)
      P_FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      P_DECODE: begin asb = 2'b11; ext = 1; ill = (op > 5); end
      P_EXEC: begin
        asa = 1;
        if (op == 0) aop = 2'b10;
        else begin asb = 2'b10; ext = 1; end
      end
      P_MEM:    begin mrd = (op == 1); mwr = (op == 2); done = (op == 2) && mr; end
      P_WB:     begin rw = 1; rd = (op == 0); m2r = (op == 1); done = 1; end
      P_BRANCH: begin asa = 1; aop = 2'b01; pcs = 2'b01; pcw = z; done = 1; end
      P_JUMP:   begin pcs = 2'b10; pcw = 1; done = 1; end
      default:  ;
    endcase
    return {pcw, irw, rw, rd, m2r, mrd, mwr, ext, asa, asb, aop, pcs, ill, done};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic drive_push(input int ph, input int op_live, input int op, input logic mr,
                            input logic z);
    exp_t e;
    opcode    = 3'(op_live);
    mem_ready = mr;
    zero      = z;
    e.st   = 3'(ph);
    e.ctrl = ctrl_of(ph, op, mr, z);
    e.cnt  = model_cnt;
    exp_q.push_back(e);
    if (e.ctrl[0]) model_cnt = model_cnt + 16'd1;
  endtask

  task automatic cycle(input int ph, input int op, input logic mr, input logic z);
    @(negedge clk);
    // Outside DECODE the opcode bus carries junk, which must be ignored.
    drive_push(ph, (ph == P_DECODE) ? op : int'($urandom_range(0, 7)), op, mr, z);
  endtask

  // Phase list of one instruction, with wf FETCH stalls and wm MEM stalls.
  task automatic run_instr(input int op, input int wf, input int wm, input logic zb,
                           input bit stop_in_mem = 0);
    for (int i = 0; i < wf; i++) cycle(P_FETCH, op, 1'b0, rb());
    cycle(P_FETCH, op, 1'b1, rb());
    cycle(P_DECODE, op, rb(), rb());
    case (op)
      0, 4: begin cycle(P_EXEC, op, rb(), rb()); cycle(P_WB, op, rb(), rb()); end
      1, 2: begin
        cycle(P_EXEC, op, rb(), rb());
        for (int i = 0; i < wm; i++) cycle(P_MEM, op, 1'b0, rb());
        if (!stop_in_mem) begin
          cycle(P_MEM, op, 1'b1, rb());
          if (op == 1) cycle(P_WB, op, rb(), rb());
        end
      end
      3: cycle(P_BRANCH, op, rb(), zb);
      5: cycle(P_JUMP, op, rb(), rb());
      default: ;
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("state", 32'(state_out), 32'(e.st));
        check("ctrl", 32'(act_ctrl), 32'(e.ctrl));
        check("count", 32'(instr_count), 32'(e.cnt));
        check("state_w2", 32'(w2_state), 32'(e.st));
        check("count_w2", 32'(w2_count), 32'(e.cnt[1:0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0; model_cnt = '0;
    repeat (2) @(negedge clk);
    #2;
    check("reset_state", 32'(state_out), 32'd0);
    check("reset_ctrl", 32'(act_ctrl), 32'd0);
    check("reset_count", 32'(instr_count), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    drive_push(P_RST, 0, 0, 1'b1, 1'b0);

    run_instr(0, 0, 0, 1'b0);
    run_instr(1, 0, 3, 1'b0);
    run_instr(3, 0, 0, 1'b1);
    run_instr(3, 0, 0, 1'b0);
    run_instr(6, 0, 0, 1'b0);
    run_instr(0, 1, 0, 1'b0);
    for (int i = 0; i < 5; i++) run_instr(5, 0, 0, 1'b0);
    run_instr(2, 2, 2, 1'b0);
    run_instr(4, 0, 0, 1'b0);
    run_instr(7, 1, 0, 1'b0);

    for (int i = 0; i < 60; i++)
      run_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), rb());

    // Abort an SW while it is stalled in MEM with MemWrite high.
    run_instr(2, 0, 1, 1'b0, 1'b1);
    #4;
    rst_n = 1'b0;
    #1;
    check("rst_memwrite", 32'(MemWrite), 32'd0);
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    model_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_push(P_RST, 0, 0, 1'b1, 1'b0);
    run_instr(5, 0, 0, 1'b0);
    run_instr(1, 1, 1, 1'b0);

    @(negedge clk);
    #4;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
